// File: rtl/csr_file_m.sv
// Machine-mode CSR file: Zicsr read-modify-write, 64-bit cycle/instret counters,
// trap entry / mret sequencing, interrupt gating and a registered fetch redirect pulse.
module csr_file_m #(
  parameter int unsigned CNT_W       = 64,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic        int_req_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] IRQ_MASK   = 32'h0000_0880;
  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;

  logic             r_st_mie;
  logic             r_st_mpie;
  logic [31:0]      r_mie;
  logic [31:0]      r_mtvec;
  logic [31:0]      r_mscratch;
  logic [31:0]      r_mepc;
  logic [31:0]      r_mcause;
  logic [31:0]      r_mtval;
  logic             r_mip_t;
  logic             r_mip_e;
  logic [CNT_W-1:0] r_mcycle;
  logic [CNT_W-1:0] r_minstret;
  logic             r_int_req;
  logic             r_redirect;
  logic [31:0]      r_redirect_pc;

  logic [31:0]      w_mstatus;
  logic [31:0]      w_mip;
  logic [63:0]      w_cyc64;
  logic [63:0]      w_ins64;
  logic [31:0]      w_rval;
  logic             w_hit;
  logic             w_ro_space;
  logic [31:0]      w_wval;
  logic             w_wr;
  logic [31:0]      w_base;
  logic [31:0]      w_trap_tgt;

  logic             w_st_mie_n;
  logic             w_st_mpie_n;
  logic [31:0]      w_mie_n;
  logic [31:0]      w_mtvec_n;
  logic [31:0]      w_mscratch_n;
  logic [31:0]      w_mepc_n;
  logic [31:0]      w_mcause_n;
  logic [31:0]      w_mtval_n;
  logic             w_redirect_n;
  logic [31:0]      w_redirect_pc_n;
  logic [CNT_W-1:0] w_mcycle_n;
  logic [CNT_W-1:0] w_minstret_n;
  logic             w_int_req_n;

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_st_mpie, 3'b0, r_st_mie, 3'b0};
  assign w_mip     = {20'b0, r_mip_e, 3'b0, r_mip_t, 7'b0};
  assign w_cyc64   = 64'(r_mcycle);
  assign w_ins64   = 64'(r_minstret);

  always_comb begin
    w_hit  = 1'b1;
    w_rval = 32'h0;
    case (csr_addr)
      A_MSTATUS:               w_rval = w_mstatus;
      A_MIE:                   w_rval = r_mie;
      A_MTVEC:                 w_rval = r_mtvec;
      A_MSCRATCH:              w_rval = r_mscratch;
      A_MEPC:                  w_rval = r_mepc;
      A_MCAUSE:                w_rval = r_mcause;
      A_MTVAL:                 w_rval = r_mtval;
      A_MIP:                   w_rval = w_mip;
      A_MCYCLE,   A_CYCLE:     w_rval = w_cyc64[31:0];
      A_MCYCLEH,  A_CYCLEH:    w_rval = w_cyc64[63:32];
      A_MINSTRET, A_INSTRET:   w_rval = w_ins64[31:0];
      A_MINSTRETH, A_INSTRETH: w_rval = w_ins64[63:32];
      A_MHARTID:               w_rval = HART_ID;
      default:                 w_hit  = 1'b0;
    endcase
  end

  assign w_ro_space  = (csr_addr[11:10] == 2'b11);
  assign csr_illegal = csr_en && (!w_hit || ((csr_op != 2'b00) && w_ro_space));
  assign csr_rdata   = csr_illegal ? 32'h0 : w_rval;

  always_comb begin
    case (csr_op)
      2'b01:   w_wval = csr_wdata;
      2'b10:   w_wval = w_rval | csr_wdata;
      2'b11:   w_wval = w_rval & ~csr_wdata;
      default: w_wval = w_rval;
    endcase
  end

  // A write that collides with a trap or mret is dropped; the read still returns the old value.
  assign w_wr = csr_en && (csr_op != 2'b00) && !csr_illegal && !trap_valid_i && !mret_i;

  assign w_base     = {r_mtvec[31:2], 2'b00};
  assign w_trap_tgt = (VECTORED_EN && (r_mtvec[1:0] == 2'b01) && trap_cause_i[31])
                    ? w_base + {25'b0, trap_cause_i[4:0], 2'b00}
                    : w_base;

  always_comb begin
    w_st_mie_n      = r_st_mie;
    w_st_mpie_n     = r_st_mpie;
    w_mie_n         = r_mie;
    w_mtvec_n       = r_mtvec;
    w_mscratch_n    = r_mscratch;
    w_mepc_n        = r_mepc;
    w_mcause_n      = r_mcause;
    w_mtval_n       = r_mtval;
    w_redirect_n    = 1'b0;
    w_redirect_pc_n = r_redirect_pc;
    if (trap_valid_i) begin
      w_mepc_n        = {trap_pc_i[31:2], 2'b00};
      w_mcause_n      = trap_cause_i;
      w_mtval_n       = trap_val_i;
      w_st_mpie_n     = r_st_mie;
      w_st_mie_n      = 1'b0;
      w_redirect_n    = 1'b1;
      w_redirect_pc_n = w_trap_tgt;
    end else if (mret_i) begin
      w_st_mie_n      = r_st_mpie;
      w_st_mpie_n     = 1'b1;
      w_redirect_n    = 1'b1;
      w_redirect_pc_n = r_mepc;
    end else if (w_wr) begin
      case (csr_addr)
        A_MSTATUS: begin
          w_st_mie_n  = w_wval[3];
          w_st_mpie_n = w_wval[7];
        end
        A_MIE:      w_mie_n      = w_wval & IRQ_MASK;
        A_MTVEC:    w_mtvec_n    = w_wval & MTVEC_MASK;
        A_MSCRATCH: w_mscratch_n = w_wval;
        A_MEPC:     w_mepc_n     = {w_wval[31:2], 2'b00};
        A_MCAUSE:   w_mcause_n   = w_wval;
        A_MTVAL:    w_mtval_n    = w_wval;
        default: ;
      endcase
    end
  end

  // A write to either counter half replaces it and suppresses that cycle's increment.
  always_comb begin
    w_mcycle_n   = r_mcycle + CNT_W'(1);
    w_minstret_n = r_minstret + CNT_W'(instret_i);
    if (w_wr) begin
      case (csr_addr)
        A_MCYCLE:    w_mcycle_n   = CNT_W'({w_cyc64[63:32], w_wval});
        A_MCYCLEH:   w_mcycle_n   = CNT_W'({w_wval, w_cyc64[31:0]});
        A_MINSTRET:  w_minstret_n = CNT_W'({w_ins64[63:32], w_wval});
        A_MINSTRETH: w_minstret_n = CNT_W'({w_wval, w_ins64[31:0]});
        default: ;
      endcase
    end
  end

  // Enables come from post-update state so a trap blanks the request on the following cycle.
  assign w_int_req_n = w_st_mie_n && |(w_mip & w_mie_n & IRQ_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_mie      <= 1'b0;
      r_st_mpie     <= 1'b0;
      r_mie         <= 32'h0;
      r_mtvec       <= MTVEC_RST & MTVEC_MASK;
      r_mscratch    <= 32'h0;
      r_mepc        <= 32'h0;
      r_mcause      <= 32'h0;
      r_mtval       <= 32'h0;
      r_mip_t       <= 1'b0;
      r_mip_e       <= 1'b0;
      r_mcycle      <= '0;
      r_minstret    <= '0;
      r_int_req     <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'h0;
    end else begin
      r_st_mie      <= w_st_mie_n;
      r_st_mpie     <= w_st_mpie_n;
      r_mie         <= w_mie_n;
      r_mtvec       <= w_mtvec_n;
      r_mscratch    <= w_mscratch_n;
      r_mepc        <= w_mepc_n;
      r_mcause      <= w_mcause_n;
      r_mtval       <= w_mtval_n;
      r_mip_t       <= irq_timer_i;
      r_mip_e       <= irq_ext_i;
      r_mcycle      <= w_mcycle_n;
      r_minstret    <= w_minstret_n;
      r_int_req     <= w_int_req_n;
      r_redirect    <= w_redirect_n;
      r_redirect_pc <= w_redirect_pc_n;
    end
  end

  assign int_req_o     = r_int_req;
  assign redirect_o    = r_redirect;
  assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: directed scenarios then randomized traffic, all checked
// against a cycle-level behavioural model of the machine CSR state.
module tb_csr_file_m;

  localparam logic [31:0] HART     = 32'h0000_0005;
  localparam logic [31:0] TVEC_RST = 32'h0000_1001;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret_i;
  logic        trap_valid_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_val_i;
  logic        mret_i;
  logic        irq_timer_i;
  logic        irq_ext_i;
  logic        int_req_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  csr_file_m #(
    .CNT_W(64), .MTVEC_RST(TVEC_RST), .HART_ID(HART), .VECTORED_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instret_i(instret_i), .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .trap_val_i(trap_val_i), .mret_i(mret_i),
    .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .int_req_o(int_req_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural model
  bit        m_st_mie, m_st_mpie;
  bit [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
  bit [63:0] m_cyc, m_ins;
  bit        m_int, m_redir;
  bit [31:0] m_rpc;
  bit [31:0] obs_rd;
  bit        obs_ill;

  function automatic bit m_read(input logic [11:0] a, output bit [31:0] v);
    v = 32'h0;
    m_read = 1'b1;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_st_mpie) << 7) | (32'(m_st_mie) << 3);
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF14: v = HART;
      default: m_read = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_st_mie = 0; m_st_mpie = 0; m_mie = 0; m_mtvec = TVEC_RST; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
    m_int = 0; m_redir = 0; m_rpc = 0;
  endtask

  task automatic model_step();
    bit [31:0] old, nv;
    bit        impl, ill, wr;
    bit [63:0] nc, ni;
    if (rst) begin
      model_reset();
      return;
    end
    impl = m_read(csr_addr, old);
    ill  = csr_en && (!impl || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11));
    wr   = csr_en && csr_op != 2'b00 && !ill && !trap_valid_i && !mret_i;
    case (csr_op)
      2'b01:   nv = csr_wdata;
      2'b10:   nv = old | csr_wdata;
      2'b11:   nv = old & ~csr_wdata;
      default: nv = old;
    endcase
    nc = m_cyc + 64'd1;
    ni = m_ins + 64'(instret_i);
    m_redir = 0;
    if (trap_valid_i) begin
      m_mepc = trap_pc_i & ~32'h3;
      m_mcause = trap_cause_i;
      m_mtval = trap_val_i;
      m_st_mpie = m_st_mie;
      m_st_mie = 0;
      m_redir = 1;
      if (m_mtvec[1:0] == 2'd1 && trap_cause_i[31])
        m_rpc = (m_mtvec & ~32'h3) + 4 * trap_cause_i[4:0];
      else
        m_rpc = m_mtvec & ~32'h3;
    end else if (mret_i) begin
      m_st_mie = m_st_mpie;
      m_st_mpie = 1;
      m_redir = 1;
      m_rpc = m_mepc;
    end else if (wr) begin
      case (csr_addr)
        12'h300: begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
        12'h304: m_mie = nv & 32'h880;
        12'h305: m_mtvec = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: nc = {m_cyc[63:32], nv};
        12'hB80: nc = {nv, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], nv};
        12'hB82: ni = {nv, m_ins[31:0]};
        default: ;
      endcase
    end
    // pending bits as sampled last cycle, enables as they stand after this edge
    m_int = m_st_mie && ((m_mip & m_mie & 32'h880) != 0);
    m_mip = (32'(irq_ext_i) << 11) | (32'(irq_timer_i) << 7);
    m_cyc = nc;
    m_ins = ni;
  endtask

  task automatic cyc();
    bit [31:0] ev;
    bit        imp, eill;
    @(negedge clk);
    if (csr_en) begin
      imp  = m_read(csr_addr, ev);
      eill = !imp || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
      check("csr_illegal", csr_illegal, eill);
      check("csr_rdata", csr_rdata, eill ? 32'h0 : ev);
      obs_rd  = csr_rdata;
      obs_ill = csr_illegal;
    end
    check("int_req_o", int_req_o, m_int);
    check("redirect_o", redirect_o, m_redir);
    check("redirect_pc_o", redirect_pc_o, m_rpc);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] o, input logic [11:0] a, input logic [31:0] d);
    csr_en = 1'b1; csr_op = o; csr_addr = a; csr_wdata = d;
    cyc();
    csr_en = 1'b0; csr_op = 2'b00;
  endtask

  logic [11:0] addrs [20] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h301, 12'h345};

  initial begin
    rst = 1; csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0; instret_i = 0;
    trap_valid_i = 0; trap_cause_i = 0; trap_pc_i = 0; trap_val_i = 0; mret_i = 0;
    irq_timer_i = 0; irq_ext_i = 0;
    @(posedge clk); #1;
    model_reset();
    cyc();
    rst = 0;

    // reset state
    op(2'b00, 12'h305, 0); check("rst_mtvec", obs_rd, TVEC_RST);
    op(2'b00, 12'h300, 0); check("rst_mstatus", obs_rd, 32'h1800);
    check("rst_redirect", redirect_o, 1'b0);

    // Zicsr RW / RS / RC
    op(2'b01, 12'h340, 32'hDEADBEEF); check("rw_old", obs_rd, 32'h0);
    op(2'b10, 12'h340, 32'h00000010); check("rs_old", obs_rd, 32'hDEADBEEF);
    op(2'b11, 12'h340, 32'hDE000000); check("rc_old", obs_rd, 32'hDEADBEFF);
    op(2'b00, 12'h340, 0);            check("mscratch", obs_rd, 32'h00ADBEFF);

    // interrupt request and vectored trap entry
    op(2'b01, 12'h305, 32'h80000001);
    op(2'b01, 12'h304, 32'h00000080);
    op(2'b10, 12'h300, 32'h00000008);
    irq_timer_i = 1;
    cyc(); cyc();
    check("int_req_set", int_req_o, 1'b1);
    trap_valid_i = 1; trap_cause_i = 32'h80000007; trap_pc_i = 32'h100; trap_val_i = 32'h1234;
    cyc();
    trap_valid_i = 0;
    check("trap_redirect", redirect_o, 1'b1);
    check("trap_pc", redirect_pc_o, 32'h8000001C);
    check("int_req_trap", int_req_o, 1'b0);
    op(2'b00, 12'h341, 0); check("trap_mepc", obs_rd, 32'h100);
    check("redirect_pulse", redirect_o, 1'b0);
    op(2'b00, 12'h300, 0); check("trap_mstatus", obs_rd, 32'h1880);
    op(2'b00, 12'h342, 0); check("trap_mcause", obs_rd, 32'h80000007);

    // mret
    mret_i = 1;
    cyc();
    mret_i = 0;
    check("mret_redirect", redirect_o, 1'b1);
    check("mret_pc", redirect_pc_o, 32'h100);
    op(2'b00, 12'h300, 0); check("mret_mstatus", obs_rd, 32'h1888);
    irq_timer_i = 0;

    // counters
    op(2'b01, 12'hB00, 32'hFFFFFFFF);
    cyc();
    op(2'b00, 12'hB80, 0); check("mcycleh_carry", obs_rd, 32'h1);
    op(2'b00, 12'hC80, 0); check("cycleh_alias", obs_rd, 32'h1);
    repeat (5) begin instret_i = 1; cyc(); instret_i = 0; cyc(); end
    op(2'b00, 12'hB02, 0); check("minstret", obs_rd, 32'h5);
    op(2'b00, 12'hC02, 0); check("instret_alias", obs_rd, 32'h5);

    // illegal accesses
    op(2'b01, 12'hF14, 32'h99); check("ill_hartid_w", obs_ill, 1'b1); check("ill_rdata", obs_rd, 32'h0);
    op(2'b01, 12'h7C0, 32'h1);  check("ill_unimpl", obs_ill, 1'b1);
    op(2'b00, 12'hF14, 0);      check("hartid_rd_ok", obs_ill, 1'b0); check("hartid", obs_rd, HART);
    op(2'b00, 12'h340, 0);      check("ill_nochange", obs_rd, 32'h00ADBEFF);

    // trap + mret + write in one cycle, then reset during the redirect
    trap_valid_i = 1; mret_i = 1; trap_cause_i = 32'h2; trap_pc_i = 32'h203; trap_val_i = 32'h0;
    op(2'b01, 12'h341, 32'h44);
    trap_valid_i = 0; mret_i = 0;
    check("coll_old_rd", obs_rd, 32'h100);
    check("coll_redirect", redirect_o, 1'b1);
    check("coll_pc", redirect_pc_o, 32'h80000000);
    rst = 1;
    op(2'b00, 12'h341, 0); check("coll_mepc", obs_rd, 32'h200);
    rst = 0;
    check("rst_cancel", redirect_o, 1'b0);
    op(2'b00, 12'h341, 0); check("rst2_mepc", obs_rd, 32'h0);
    op(2'b00, 12'h300, 0); check("rst2_mstatus", obs_rd, 32'h1800);
    op(2'b00, 12'h305, 0); check("rst2_mtvec", obs_rd, TVEC_RST);
    op(2'b00, 12'h340, 0); check("rst2_mscratch", obs_rd, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      csr_en       = 1'($urandom);
      csr_op       = 2'($urandom);
      csr_addr     = addrs[$urandom_range(0, 19)];
      csr_wdata    = $urandom;
      instret_i    = 1'($urandom);
      trap_valid_i = ($urandom_range(0, 15) == 0);
      mret_i       = ($urandom_range(0, 11) == 0);
      trap_cause_i = $urandom;
      trap_pc_i    = $urandom;
      trap_val_i   = $urandom;
      irq_timer_i  = 1'($urandom);
      irq_ext_i    = 1'($urandom);
      rst          = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
